regfile_bist: RTL and testbench

Built-in self-test initiator for the 32x32 two-read/one-write register file. It drives the register file's write and read ports, then checks both read ports against expected data. It sits between the register file and the top-level test/status logic, and reports a pass/fail verdict and the first failing register. It covers four properties: write path, write-enable gating, hard-wired zero register, and read-port independence.

---
 rtl/regfile_bist_pkg.sv | 50 +++++
 rtl/regfile_bist_if.sv | 36 +++
 rtl/regfile_bist_cmp.sv | 40 ++++
 rtl/regfile_bist.sv | 157 +++++++++++++++
 tb/tb_regfile_bist.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_bist_pkg.sv
// regfile_bist_pkg: shared types and helpers for the register-file BIST.
//   state_e          run-order FSM states
//   PHASE_*          FailPhase codes reported for the read phase of a mismatch
//   PHASE_LEN        registers visited per phase
//   pat()            data pattern generator
//   next_phase()     run-order successor of a non-idle state
package regfile_bist_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StW0,
        StR0,
        StWx,
        StRx,
        StW1,
        StR1,
        StDone
    } state_e;

    localparam logic [1:0] PHASE_R0 = 2'd0;
    localparam logic [1:0] PHASE_RX = 2'd1;
    localparam logic [1:0] PHASE_R1 = 2'd2;

    localparam int unsigned PHASE_LEN = 32;
    localparam logic [4:0]  IDX_LAST  = 5'(PHASE_LEN - 1);

    // pat0(r) = seed + r, pat1(r) = ~pat0(r), all mod 2^32.
    function automatic logic [31:0] pat(input logic [31:0] seed,
                                        input logic [4:0]  r,
                                        input logic        inv);
        logic [31:0] p;
        p = seed + {27'd0, r};
        return inv ? ~p : p;
    endfunction

    function automatic state_e next_phase(input state_e s);
        state_e n;
        unique case (s)
            StW0:    n = StR0;
            StR0:    n = StWx;
            StWx:    n = StRx;
            StRx:    n = StW1;
            StW1:    n = StR1;
            StR1:    n = StDone;
            default: n = StIdle;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/regfile_bist_if.sv
// regfile_bist_if: port bundle between the BIST initiator and the 32x32 2R1W register file.
//   WriteData/WriteRegister/RegWrite   write port (BIST -> regfile)
//   ReadRegister1/ReadRegister2        read addresses (BIST -> regfile)
//   ReadData1/ReadData2                combinational read data (regfile -> BIST)
// master: the BIST side; slave: the register file side.
interface regfile_bist_if;

    logic [31:0] WriteData;
    logic [4:0]  WriteRegister;
    logic        RegWrite;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    modport master (
        output WriteData,
        output WriteRegister,
        output RegWrite,
        output ReadRegister1,
        output ReadRegister2,
        input  ReadData1,
        input  ReadData2
    );

    modport slave (
        input  WriteData,
        input  WriteRegister,
        input  RegWrite,
        input  ReadRegister1,
        input  ReadRegister2,
        output ReadData1,
        output ReadData2
    );

endinterface

// File: rtl/regfile_bist_cmp.sv
// regfile_bist_cmp: combinational check of both read ports against the expected pattern.
//   idx_i       current index; port 1 reads idx, port 2 reads 31-idx
//   inv_i       1 when the expected data is pat1 (R1 phase)
//   rdata1_i    ReadData1 from the register file
//   rdata2_i    ReadData2 from the register file
//   mismatch_o  hit flag: either port differs from its expected value
//   fail_reg_o  failing register, port 1 taking priority over port 2
module regfile_bist_cmp
    import regfile_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hA5A5_0000
) (
    input  logic [4:0]  idx_i,
    input  logic        inv_i,
    input  logic [31:0] rdata1_i,
    input  logic [31:0] rdata2_i,
    output logic        mismatch_o,
    output logic [4:0]  fail_reg_o
);

    logic [4:0]  addr1;
    logic [4:0]  addr2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic        miss1;
    logic        miss2;

    always_comb begin
        addr1 = idx_i;
        addr2 = IDX_LAST - idx_i;
        // Register 0 is hard-wired to zero regardless of what was written.
        exp1  = (addr1 == 5'd0) ? 32'd0 : pat(SEED, addr1, inv_i);
        exp2  = (addr2 == 5'd0) ? 32'd0 : pat(SEED, addr2, inv_i);
        miss1 = (rdata1_i != exp1);
        miss2 = (rdata2_i != exp2);
        mismatch_o = miss1 | miss2;
        fail_reg_o = miss1 ? addr1 : addr2;
    end

endmodule

// File: rtl/regfile_bist.sv
// regfile_bist: built-in self-test initiator for the 32x32 two-read/one-write register file.
// Runs W0 (write pat0), R0 (check), WX (write pat1 with RegWrite=0), RX (check pat0 survived),
// W1 (write pat1), R1 (check), then reports a verdict in DONE.
//   Clk        clock, rising edge
//   Reset_n    asynchronous active-low reset
//   Start      begin a run; honoured only in IDLE and DONE
//   Busy       run in progress
//   Done       verdict available; held until the next run or reset
//   Pass       verdict, valid while Done
//   FailReg    register index of the first mismatch
//   FailPhase  read phase of the first mismatch (PHASE_R0/RX/R1)
//   rf         register-file write/read ports (master side)
module regfile_bist
    import regfile_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hA5A5_0000
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Pass,
    output logic [4:0]            FailReg,
    output logic [1:0]            FailPhase,
    regfile_bist_if.master        rf
);

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        pass_q, pass_d;
    logic [4:0]  fail_reg_q, fail_reg_d;
    logic [1:0]  fail_phase_q, fail_phase_d;

    logic        read_inv;
    logic [1:0]  read_phase;
    logic        mismatch;
    logic [4:0]  cmp_fail_reg;
    state_e      phase_next;

    regfile_bist_cmp #(
        .SEED (SEED)
    ) u_cmp (
        .idx_i      (idx_q),
        .inv_i      (read_inv),
        .rdata1_i   (rf.ReadData1),
        .rdata2_i   (rf.ReadData2),
        .mismatch_o (mismatch),
        .fail_reg_o (cmp_fail_reg)
    );

    // Register-file drive: Moore function of state and idx only.
    always_comb begin
        rf.WriteData     = '0;
        rf.WriteRegister = '0;
        rf.RegWrite      = 1'b0;
        rf.ReadRegister1 = '0;
        rf.ReadRegister2 = '0;
        read_inv         = 1'b0;
        read_phase       = PHASE_R0;
        unique case (state_q)
            StW0: begin
                rf.WriteRegister = idx_q;
                rf.WriteData     = pat(SEED, idx_q, 1'b0);
                rf.RegWrite      = 1'b1;
            end
            StWx: begin
                // Enable held low: the register file must ignore this data.
                rf.WriteRegister = idx_q;
                rf.WriteData     = pat(SEED, idx_q, 1'b1);
            end
            StW1: begin
                rf.WriteRegister = idx_q;
                rf.WriteData     = pat(SEED, idx_q, 1'b1);
                rf.RegWrite      = 1'b1;
            end
            StR0, StRx, StR1: begin
                rf.ReadRegister1 = idx_q;
                rf.ReadRegister2 = IDX_LAST - idx_q;
                read_inv         = (state_q == StR1);
                read_phase       = (state_q == StR0) ? PHASE_R0 :
                                   (state_q == StRx) ? PHASE_RX : PHASE_R1;
            end
            default: ;
        endcase
    end

    // Next-state, index and verdict.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pass_d       = pass_q;
        fail_reg_d   = fail_reg_q;
        fail_phase_d = fail_phase_q;
        phase_next   = next_phase(state_q);
        unique case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    state_d      = StW0;
                    idx_d        = '0;
                    pass_d       = 1'b0;
                    fail_reg_d   = '0;
                    fail_phase_d = '0;
                end
            end
            StW0, StWx, StW1: begin
                idx_d = idx_q + 5'd1;
                if (idx_q == IDX_LAST) begin
                    state_d = phase_next;
                end
            end
            StR0, StRx, StR1: begin
                if (mismatch) begin
                    // Leaving for DONE right away means only the first mismatch is kept.
                    state_d      = StDone;
                    idx_d        = '0;
                    pass_d       = 1'b0;
                    fail_reg_d   = cmp_fail_reg;
                    fail_phase_d = read_phase;
                end else begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d = phase_next;
                        pass_d  = (phase_next == StDone);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            pass_q       <= 1'b0;
            fail_reg_q   <= '0;
            fail_phase_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pass_q       <= pass_d;
            fail_reg_q   <= fail_reg_d;
            fail_phase_q <= fail_phase_d;
        end
    end

    assign Busy      = (state_q != StIdle) && (state_q != StDone);
    assign Done      = (state_q == StDone);
    assign Pass      = pass_q;
    assign FailReg   = fail_reg_q;
    assign FailPhase = fail_phase_q;

endmodule

// File: tb/tb_regfile_bist.sv
// tb_regfile_bist: self-checking bench for regfile_bist with a behavioural register file
// that can be switched into several faulty modes.
module tb_regfile_bist;

    typedef struct {
        int         mode;
        logic       busy_pulses;
        logic       exp_pass;
        logic [1:0] exp_phase;
        logic [4:0] exp_reg;
        int         exp_lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  fail_reg;
    logic [1:0]  fail_phase;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          mode     = 0;
    vec_t        sb[$];
    vec_t        vecs[9];
    vec_t        good;

    logic [31:0] regs [32];
    logic [31:0] rd1;
    logic [31:0] rd2;

    regfile_bist_if rf_bus ();

    regfile_bist #(
        .SEED (32'hA5A5_0000)
    ) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .Start     (start),
        .Busy      (busy),
        .Done      (done),
        .Pass      (pass),
        .FailReg   (fail_reg),
        .FailPhase (fail_phase),
        .rf        (rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model. Modes: 0 good, 1 ignores RegWrite, 2 reg0 writable,
    // 3 ReadData2 stuck on reg17, 4 port1 reg9 bit3 flipped, 5 port2 reg22 bit0 flipped,
    // 6 both ports flip bit4 of reg5/reg26, 7 drops writes to reg12 with data bit31 clear.
    always @(posedge clk) begin
        if ((rf_bus.RegWrite || mode == 1) &&
            (rf_bus.WriteRegister != 5'd0 || mode == 2) &&
            !(mode == 7 && rf_bus.WriteRegister == 5'd12 && !rf_bus.WriteData[31]))
            regs[rf_bus.WriteRegister] <= rf_bus.WriteData;
    end

    always_comb begin
        rd1 = (rf_bus.ReadRegister1 == 5'd0 && mode != 2) ? 32'd0 : regs[rf_bus.ReadRegister1];
        rd2 = (rf_bus.ReadRegister2 == 5'd0 && mode != 2) ? 32'd0 : regs[rf_bus.ReadRegister2];
        if (mode == 3) rd2 = regs[17];
        if (mode == 4 && rf_bus.ReadRegister1 == 5'd9) rd1 = rd1 ^ 32'h8;
        if (mode == 5 && rf_bus.ReadRegister2 == 5'd22) rd2 = rd2 ^ 32'h1;
        if (mode == 6 && (rf_bus.ReadRegister1 == 5'd5 || rf_bus.ReadRegister1 == 5'd26))
            rd1 = rd1 ^ 32'h10;
        if (mode == 6 && (rf_bus.ReadRegister2 == 5'd5 || rf_bus.ReadRegister2 == 5'd26))
            rd2 = rd2 ^ 32'h10;
    end

    assign rf_bus.ReadData1 = rd1;
    assign rf_bus.ReadData2 = rd2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Waits for Done; optionally pulses Start while busy. lat = -1 if the budget expires.
    task automatic wait_done(input int from_n, input logic pulses, output int lat);
        lat = -1;
        for (int n = from_n + 1; n <= 400; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            start = pulses && (n == 10 || n == 100);
        end
        start = 1'b0;
    endtask

    // Scoreboard pop: compare the verdict against the expectation pushed at launch.
    task automatic score(input string tag, input int lat);
        vec_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " latency"},   32'(lat),        32'(e.exp_lat));
            check({tag, " Pass"},      32'(pass),       32'(e.exp_pass));
            check({tag, " FailReg"},   32'(fail_reg),   32'(e.exp_reg));
            check({tag, " FailPhase"}, 32'(fail_phase), 32'(e.exp_phase));
            check({tag, " Busy"},      32'(busy),       32'd0);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        mode = v.mode;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        start = 1'b0;
        wait_done(0, v.busy_pulses, lat);
        score(tag, lat);
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        good = '{0, 1'b0, 1'b1, 2'd0, 5'd0, 192};
        vecs[0] = good;
        vecs[1] = '{0, 1'b1, 1'b1, 2'd0, 5'd0,  192};
        vecs[2] = '{1, 1'b0, 1'b0, 2'd1, 5'd31, 97};
        vecs[3] = '{2, 1'b0, 1'b0, 2'd0, 5'd0,  33};
        vecs[4] = '{3, 1'b0, 1'b0, 2'd0, 5'd31, 33};
        vecs[5] = '{4, 1'b0, 1'b0, 2'd0, 5'd9,  42};
        vecs[6] = '{5, 1'b0, 1'b0, 2'd0, 5'd22, 42};
        vecs[7] = '{6, 1'b0, 1'b0, 2'd0, 5'd5,  38};
        vecs[8] = '{7, 1'b0, 1'b0, 2'd2, 5'd12, 173};

        // Reset state.
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst Busy",          32'(busy),                   32'd0);
        check("rst Done",          32'(done),                   32'd0);
        check("rst Pass",          32'(pass),                   32'd0);
        check("rst FailReg",       32'(fail_reg),               32'd0);
        check("rst FailPhase",     32'(fail_phase),             32'd0);
        check("rst RegWrite",      32'(rf_bus.RegWrite),        32'd0);
        check("rst WriteData",     rf_bus.WriteData,            32'd0);
        check("rst WriteRegister", 32'(rf_bus.WriteRegister),   32'd0);
        check("rst ReadRegister1", 32'(rf_bus.ReadRegister1),   32'd0);
        check("rst ReadRegister2", 32'(rf_bus.ReadRegister2),   32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle Busy", 32'(busy), 32'd0);

        // Good run with interface sampling at chosen cycles.
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(good);
        @(negedge clk);
        start = 1'b0;
        check("w0 Busy at k",     32'(busy),                 32'd1);
        check("w0 idx0 RegWrite", 32'(rf_bus.RegWrite),      32'd1);
        check("w0 idx0 data",     rf_bus.WriteData,          32'hA5A5_0000);
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            if (n == 3) begin
                check("w0 idx3 WriteRegister", 32'(rf_bus.WriteRegister), 32'd3);
                check("w0 idx3 WriteData",     rf_bus.WriteData,          32'hA5A5_0003);
            end
            if (n == 36) begin
                check("r0 idx4 ReadRegister1", 32'(rf_bus.ReadRegister1), 32'd4);
                check("r0 idx4 ReadRegister2", 32'(rf_bus.ReadRegister2), 32'd27);
                check("r0 idx4 RegWrite",      32'(rf_bus.RegWrite),      32'd0);
            end
            if (n == 66) begin
                check("wx idx2 RegWrite",      32'(rf_bus.RegWrite),      32'd0);
                check("wx idx2 WriteRegister", 32'(rf_bus.WriteRegister), 32'd2);
                check("wx idx2 WriteData",     rf_bus.WriteData,          32'h5A5A_FFFD);
            end
            if (n == 165) begin
                check("r1 idx5 ReadRegister1", 32'(rf_bus.ReadRegister1), 32'd5);
                check("r1 idx5 ReadData1",     rf_bus.ReadData1,          32'h5A5A_FFFA);
            end
            if (n == 191) check("busy before done", 32'(busy), 32'd1);
        end
        score("sampled", lat);
        repeat (4) @(negedge clk);
        check("done held",         32'(done),                 32'd1);
        check("done RegWrite",     32'(rf_bus.RegWrite),      32'd0);
        check("done ReadRegister2", 32'(rf_bus.ReadRegister2), 32'd0);

        // Vector table.
        for (int i = 0; i < 9; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Start held across DONE -> W0 clears the previous failure (FailReg=12, FailPhase=2).
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(good);
        @(negedge clk);
        check("restart Busy",      32'(busy),       32'd1);
        check("restart Done",      32'(done),       32'd0);
        check("restart FailReg",   32'(fail_reg),   32'd0);
        check("restart FailPhase", 32'(fail_phase), 32'd0);
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(2, 1'b0, lat);
        score("held start", lat);

        // Restart after a passing run clears Pass.
        @(negedge clk);
        start = 1'b1;
        sb.push_back(good);
        @(negedge clk);
        start = 1'b0;
        check("restart clears Pass", 32'(pass), 32'd0);
        wait_done(0, 1'b0, lat);
        score("rerun", lat);

        // Reset in W0: RegWrite drops without waiting for a clock edge.
        launch();
        repeat (10) @(negedge clk);
        check("pre-reset RegWrite", 32'(rf_bus.RegWrite), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset RegWrite",  32'(rf_bus.RegWrite), 32'd0);
        check("async reset Busy",      32'(busy),            32'd0);
        check("async reset WriteData", rf_bus.WriteData,     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset at cycle 50 (R0): aborted with no verdict, then a clean run passes.
        launch();
        repeat (50) @(negedge clk);
        check("pre-reset ReadRegister1", 32'(rf_bus.ReadRegister1), 32'd18);
        #1 rst_n = 1'b0;
        #1;
        check("abort Busy",          32'(busy),                 32'd0);
        check("abort Done",          32'(done),                 32'd0);
        check("abort RegWrite",      32'(rf_bus.RegWrite),      32'd0);
        check("abort ReadRegister1", 32'(rf_bus.ReadRegister1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("after reset", good);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
